regfile_wb: RTL and testbench

- 32 x 64-bit ARM register file, the write-back destination of the pipeline.
- Sits directly downstream of the 5:32 write-enable decoder. It consumes the one-hot write enables that decoder produces from RegWrite and the write address.
- Provides two read ports to the decode stage.
- X31 (XZR) always reads zero.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/decoder5_32.sv | 18 +
 rtl/regfile_wb.sv | 81 ++++++++
 tb/tb_regfile_wb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, sizes and types for the write-back register file.
// Everything that sizes regfile_wb or its decoder lives here.
package regfile_pkg;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int NREGS    = 2 ** ADDR_W;
   localparam int ZERO_REG = NREGS - 1;

   typedef logic [DATA_W-1:0] reg_t;
   typedef logic [ADDR_W-1:0] raddr_t;

endpackage

// File: rtl/decoder5_32.sv
// 5:32 write-enable decoder, combinational, no backpressure.
// Bit order is reversed: o_outbus[31] selects register 0, o_outbus[0] selects register 31.
module decoder5_32
   import regfile_pkg::*;
(
   input  logic             i_en,
   input  logic [4:0]       i_sel,
   output logic [31:0]      o_outbus
);

   always_comb begin
      o_outbus = '0;
      if (i_en) begin
         o_outbus[5'd31 - i_sel] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wb.sv
// 32x64 register file: 1-cycle write latency, combinational reads with optional same-cycle bypass.
// X31 reads zero; no backpressure, a write is accepted on every edge it is presented.
module regfile_wb
   import regfile_pkg::*;
#(
   parameter int BYPASS = 1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteRegister,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   logic [NREGS-1:0] w_outbus;
   logic [NREGS-1:0] w_we;
   reg_t             r_regs [0:NREGS-2];

   decoder5_32 u_dec (
      .i_en     (RegWrite),
      .i_sel    (WriteRegister),
      .o_outbus (w_outbus)
   );

   // Decoder numbers its outputs from the top down; flip back to register order.
   always_comb begin
      w_we = '0;
      for (int i = 0; i < NREGS; i++) begin
         w_we[i] = w_outbus[NREGS-1-i];
      end
   end

   // No flop exists for ZERO_REG, so its enable is simply never consumed.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS-1; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS-1; i++) begin
            if (w_we[i]) begin
               r_regs[i] <= WriteData;
            end
         end
      end
   end

   function automatic reg_t read_port(input raddr_t a);
      reg_t v;
      v = '0;
      if (!reset || a == raddr_t'(ZERO_REG)) begin
         v = '0;
      end else if (BYPASS != 0 && RegWrite && WriteRegister == a) begin
         v = WriteData;
      end else begin
         for (int i = 0; i < NREGS-1; i++) begin
            if (a == raddr_t'(i)) begin
               v = r_regs[i];
            end
         end
      end
      return v;
   endfunction

   always_comb begin
      ReadData1 = read_port(ReadRegister1);
   end

   always_comb begin
      ReadData2 = read_port(ReadRegister2);
   end

   a_we_onehot : assert property (@(posedge clk)
      RegWrite ? $onehot(w_outbus) : (w_outbus == '0));

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: one bypassing instance and one non-bypassing instance share stimulus.
module tb_regfile_wb;
   import regfile_pkg::*;

   logic        clk;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

   int n_cmp;
   int n_err;

   regfile_wb #(.BYPASS(1)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (rd1_b),
      .ReadData2     (rd2_b)
   );

   regfile_wb #(.BYPASS(0)) u_dut_nb (
      .clk           (clk),
      .reset         (reset),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (rd1_n),
      .ReadData2     (rd2_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      logic [63:0] exp;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      RegWrite = 1'b0;
      WriteRegister = '0;
      WriteData = '0;
      ReadRegister1 = '0;
      ReadRegister2 = '0;

      // reset held for two edges, then every index on both ports
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(31 - i);
         settle();
         chk($sformatf("reset_rd1[%0d]", i), rd1_b, 64'h0);
         chk($sformatf("reset_rd2[%0d]", 31 - i), rd2_b, 64'h0);
      end

      // fill 0..30 and read back on both ports
      RegWrite = 1'b1;
      for (int i = 0; i < 31; i++) begin
         WriteRegister = 5'(i);
         WriteData = 64'hA5A5_0000_0000_0000 + 64'(i);
         tick();
      end
      RegWrite = 1'b0;
      for (int i = 0; i < 31; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(30 - i);
         settle();
         chk($sformatf("wr_rd1[%0d]", i), rd1_b, 64'hA5A5_0000_0000_0000 + 64'(i));
         chk($sformatf("wr_rd2[%0d]", 30 - i), rd2_b, 64'hA5A5_0000_0000_0000 + 64'(30 - i));
      end

      // zero register: no bypass, no storage
      RegWrite = 1'b1;
      WriteRegister = 5'd31;
      WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
      ReadRegister1 = 5'd31;
      ReadRegister2 = 5'd30;
      settle();
      chk("xzr_same_cycle", rd1_b, 64'h0);
      tick();
      RegWrite = 1'b0;
      settle();
      chk("xzr_after", rd1_b, 64'h0);
      chk("xzr_r30_intact", rd2_b, 64'hA5A5_0000_0000_001E);

      // bypass vs no bypass
      RegWrite = 1'b1;
      WriteRegister = 5'd5;
      WriteData = 64'h1;
      tick();
      WriteData = 64'h2;
      ReadRegister1 = 5'd5;
      ReadRegister2 = 5'd5;
      settle();
      chk("byp_rd1", rd1_b, 64'h2);
      chk("byp_rd2", rd2_b, 64'h2);
      chk("nobyp_rd1", rd1_n, 64'h1);
      chk("nobyp_rd2", rd2_n, 64'h1);
      tick();
      RegWrite = 1'b0;
      settle();
      chk("nobyp_after", rd1_n, 64'h2);
      chk("byp_after", rd2_b, 64'h2);

      // RegWrite low: reg 7 untouched over three edges, no bypass either
      RegWrite = 1'b0;
      WriteRegister = 5'd7;
      WriteData = 64'hDEAD;
      ReadRegister1 = 5'd7;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("gate_r7_%0d", k), rd1_b, 64'hA5A5_0000_0000_0007);
         tick();
      end

      // back-to-back writes to reg 9
      RegWrite = 1'b1;
      WriteRegister = 5'd9;
      WriteData = 64'h11;
      ReadRegister1 = 5'd9;
      ReadRegister2 = 5'd9;
      tick();
      WriteData = 64'h22;
      settle();
      chk("b2b_first_nb", rd1_n, 64'h11);
      tick();
      RegWrite = 1'b0;
      settle();
      chk("b2b_last_b", rd1_b, 64'h22);
      chk("b2b_last_nb", rd2_n, 64'h22);

      // mid-operation reset with a write to reg 3 pending
      reset = 1'b0;
      RegWrite = 1'b1;
      WriteRegister = 5'd3;
      WriteData = 64'hBEEF;
      ReadRegister1 = 5'd3;
      ReadRegister2 = 5'd10;
      settle();
      chk("rst_comb_rd1", rd1_b, 64'h0);
      chk("rst_comb_rd2", rd2_b, 64'h0);
      tick();
      reset = 1'b1;
      RegWrite = 1'b0;
      for (int i = 0; i < 31; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(i);
         settle();
         chk($sformatf("midrst_b[%0d]", i), rd1_b, 64'h0);
         chk($sformatf("midrst_nb[%0d]", i), rd2_n, 64'h0);
      end
      RegWrite = 1'b1;
      WriteRegister = 5'd3;
      WriteData = 64'h1234;
      ReadRegister1 = 5'd3;
      ReadRegister2 = 5'd3;
      tick();
      RegWrite = 1'b0;
      settle();
      exp = 64'h1234;
      chk("post_rst_wr_b", rd1_b, exp);
      chk("post_rst_wr_nb", rd2_n, exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
